core_debug_regs: RTL and testbench
==================================

# core_debug_regs

Parametrised run-control and performance-counter register block for the pipelined core. Two independent 32-bit register slaves: s1 for the CPU itself, s2 for JTAG. Provides:
- a cycle counter and an instructions-retired counter;
- NUM_EVENTS per-event counters, fed from hazard-unit stall and flush strobes;
- a free-run/step clock-enable (`core_run`) that gates the whole core pipeline.

## Interface
Parameters:
- NUM_EVENTS, 4: number of event counters; legal 1..12.
- CNT_WIDTH, 48: width of every counter; legal 33..64; H words zero-extended above CNT_WIDTH.

Ports:
- clk  in  1  core clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- retire  in  1  one instruction leaves WB this cycle.
- event_in  in  NUM_EVENTS  per-event strobes, e.g. if_stall, de_flush, ex_flush, stall_all.
- core_run  out  1  clock enable to the core pipeline.
- halted  out  1  high when core_run is low.
- s1_address  in  6  CPU-port word address.
- s1_read  in  1  CPU-port read strobe.
- s1_readdata  out  32  CPU-port read data.
- s1_write  in  1  CPU-port write strobe.
- s1_writedata  in  32  CPU-port write data.
- s2_address, s2_read, s2_readdata, s2_write, s2_writedata: JTAG port; same widths and meanings as s1.

## Operation
Register map (word addresses):
- 0 CTRL (RW): bit0 MODE (0 free-run, 1 step); bit1 HALT_REQ; bit2 CNT_CLR (write-1, self-clearing, reads 0).
- 1 STATUS (RO): bit0 core_run, bit1 halted, bit2 STEP_DONE.
  - STEP_DONE sets when STEPS goes 1→0 in step mode.
  - STEP_DONE clears on any write to STEPS.
- 2 STEPS (RW): 32-bit down-counter.
- 3/4 CYCLE_L/H, 5/6 INSTRET_L/H (RO).
- 8+2i / 9+2i: EVT_i_L / EVT_i_H (RO), i < NUM_EVENTS.
- Unmapped addresses read 0; writes to RO or unmapped addresses are ignored.

Run control:
- core_run = !HALT_REQ && (MODE==0 || STEPS!=0).
- In step mode, STEPS decrements by 1 on every cycle where core_run=1. It never wraps below 0.

Counting (only in cycles where core_run=1):
- CYCLE increments by 1.
- INSTRET increments when retire=1.
- EVT_i increments when event_in[i]=1.
- All counters wrap modulo 2^CNT_WIDTH.
- CNT_CLR zeroes all counters on the cycle after the write. Any increment in that cycle is discarded.

Atomic 64-bit reads:
- Each port has its own shadow register.
- A read of any *_L address latches the matching H value into that port's shadow in the same cycle.
- A subsequent read of *_H on that port returns the shadow, not the live value.

Collisions:
- Both ports write the same register in the same cycle: s2 wins.
- A write to STEPS beats a same-cycle decrement.
- Reads never have side effects, except the shadow latch.

## Timing
- Reset values:
  - all registers, counters and shadows are 0;
  - core_run=1, halted=0;
  - s1_readdata=0, s2_readdata=0.
  - The core therefore free-runs after reset.
- Read latency is 1 cycle: address and read sampled at edge N, readdata valid after edge N+1. readdata holds its value until the next read.
- A write takes effect at the edge where it is sampled. core_run reflects the new CTRL/STEPS in the following cycle.
- Writing STEPS=k at edge N (MODE=1, no halt) gives core_run=1 for exactly k cycles, starting the cycle after N. STEP_DONE=1 from the cycle core_run drops.
- HALT_REQ drops core_run the cycle after the write. STEPS is frozen while halted.
- reset asserted mid-step clears STEPS and MODE; the core resumes free-run.
- Counters sample their strobes at the same edge as the core, using core_run of that cycle.

## Configuration
- Macro CORE_DBG_EVENT_CNT_EN.
- Defined: EVT_i counters and their addresses are implemented as above.
- Undefined:
  - no event counters are synthesised;
  - addresses 8..31 read 0;
  - event_in is ignored.
- CYCLE, INSTRET, STEPS and run control are unaffected either way.

## Test plan
- Reset, then 10 cycles with retire=1 in 6 of them → CYCLE_L=10, INSTRET_L=6, core_run=1, STATUS=0x1.
- Write CTRL=1 then STEPS=3 via s2 → core_run high for exactly 3 cycles; STEPS reads 0; STATUS=0x6 (halted, STEP_DONE).
- Same cycle: s1 writes STEPS=5, s2 writes STEPS=9 → STEPS reads 9. Next, HALT_REQ=1 → core_run=0 next cycle; CYCLE stops.
- Preload CYCLE to 0x00FF_FFFF_FFFF (CNT_WIDTH=48), read CYCLE_L, let 1 cycle pass, read CYCLE_H → L=0xFFFF_FFFF, H=0x0000_00FF (shadow, not 0x100). After wrap the counter is 0.
- event_in=4'b0101 for 7 run cycles, then write CNT_CLR → EVT0=EVT2=7 and EVT1=0 before the clear; all counters 0 after; CTRL bit2 reads 0. With macro undefined → address 8 reads 0.
- Assert reset during step with STEPS=20 → next cycle STEPS=0, MODE=0, core_run=1, both readdata=0.

Source files
------------

// File: rtl/core_debug_regs.sv
// core_debug_regs: run control, step counter and perf counters on two register ports.
// Define CORE_DBG_EVENT_CNT_EN to build the per-event counters.
module core_debug_regs #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  retire,
  input  logic [NUM_EVENTS-1:0] event_in,
  output logic                  core_run,
  output logic                  halted,
  input  logic [5:0]            s1_address,
  input  logic                  s1_read,
  output logic [31:0]           s1_readdata,
  input  logic                  s1_write,
  input  logic [31:0]           s1_writedata,
  input  logic [5:0]            s2_address,
  input  logic                  s2_read,
  output logic [31:0]           s2_readdata,
  input  logic                  s2_write,
  input  logic [31:0]           s2_writedata
);

  localparam logic [5:0] A_CTRL  = 6'd0;
  localparam logic [5:0] A_STAT  = 6'd1;
  localparam logic [5:0] A_STEPS = 6'd2;
  localparam logic [5:0] A_CYC_L = 6'd3;
  localparam logic [5:0] A_CYC_H = 6'd4;
  localparam logic [5:0] A_INS_L = 6'd5;
  localparam logic [5:0] A_INS_H = 6'd6;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic                 mode_q;
  logic                 halt_q;
  logic                 done_q;
  logic [31:0]          steps_q;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] instret_q;
  logic [63:0]          cyc64;
  logic [63:0]          ins64;

  logic [5:0]  addr     [2];
  logic        rd       [2];
  logic [31:0] rdata_q  [2];
  logic [31:0] shadow_q [2];
  logic [31:0] rmux     [2];
  logic [31:0] hmux     [2];
  logic        lo_hit   [2];

  logic        w1_ctrl;
  logic        w2_ctrl;
  logic        w1_steps;
  logic        w2_steps;
  logic        wr_ctrl;
  logic        wr_steps;
  logic        cnt_clr;
  logic [2:0]  ctrl_wd;
  logic [31:0] steps_wd;

  assign addr[0] = s1_address;
  assign addr[1] = s2_address;
  assign rd[0]   = s1_read;
  assign rd[1]   = s2_read;

  assign s1_readdata = rdata_q[0];
  assign s2_readdata = rdata_q[1];

  assign core_run = !halt_q && (!mode_q || steps_q != 32'd0);
  assign halted   = !core_run;

  assign cyc64 = 64'(cycle_q);
  assign ins64 = 64'(instret_q);

  assign w1_ctrl  = s1_write && s1_address == A_CTRL;
  assign w2_ctrl  = s2_write && s2_address == A_CTRL;
  assign w1_steps = s1_write && s1_address == A_STEPS;
  assign w2_steps = s2_write && s2_address == A_STEPS;

  // s2 (JTAG) wins when both ports hit the same register
  assign wr_ctrl  = w1_ctrl || w2_ctrl;
  assign wr_steps = w1_steps || w2_steps;
  assign ctrl_wd  = w2_ctrl ? s2_writedata[2:0] : s1_writedata[2:0];
  assign steps_wd = w2_steps ? s2_writedata : s1_writedata;
  assign cnt_clr  = wr_ctrl && ctrl_wd[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= 1'b0;
      halt_q  <= 1'b0;
      done_q  <= 1'b0;
      steps_q <= '0;
    end else begin
      if (wr_ctrl) begin
        mode_q <= ctrl_wd[0];
        halt_q <= ctrl_wd[1];
      end
      if (wr_steps) begin
        steps_q <= steps_wd;
        done_q  <= 1'b0;
      end else if (core_run && mode_q) begin
        steps_q <= steps_q - 32'd1;
        if (steps_q == 32'd1) done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (core_run) begin
      cycle_q <= cycle_q + ONE;
      if (retire) instret_q <= instret_q + ONE;
    end
  end

`ifdef CORE_DBG_EVENT_CNT_EN
  logic [CNT_WIDTH-1:0] evt_q   [NUM_EVENTS];
  logic [63:0]          evt_ext [16];
  logic [3:0]           eidx    [2];
  logic                 evt_hit [2];

  always_comb begin
    for (int i = 0; i < 16; i++) evt_ext[i] = '0;
    for (int i = 0; i < NUM_EVENTS; i++) evt_ext[i] = 64'(evt_q[i]);
  end

  // addresses 8..31 map to event pairs; index = addr/2 - 4
  for (genvar p = 0; p < 2; p++) begin : g_eidx
    assign eidx[p]    = addr[p][4:1] - 4'd4;
    assign evt_hit[p] = !addr[p][5] && (addr[p][4] || addr[p][3])
                        && (int'(eidx[p]) < NUM_EVENTS);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (reset || cnt_clr) evt_q[i] <= '0;
      else if (core_run && event_in[i]) evt_q[i] <= evt_q[i] + ONE;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = ^event_in;
`endif

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rmux[p]   = '0;
      hmux[p]   = '0;
      lo_hit[p] = 1'b0;
      case (addr[p])
        A_CTRL:  rmux[p] = {30'd0, halt_q, mode_q};
        A_STAT:  rmux[p] = {29'd0, done_q, halted, core_run};
        A_STEPS: rmux[p] = steps_q;
        A_CYC_L: begin
          rmux[p]   = cyc64[31:0];
          hmux[p]   = cyc64[63:32];
          lo_hit[p] = 1'b1;
        end
        A_CYC_H: rmux[p] = shadow_q[p];
        A_INS_L: begin
          rmux[p]   = ins64[31:0];
          hmux[p]   = ins64[63:32];
          lo_hit[p] = 1'b1;
        end
        A_INS_H: rmux[p] = shadow_q[p];
        default: ;
      endcase
`ifdef CORE_DBG_EVENT_CNT_EN
      if (evt_hit[p]) begin
        if (addr[p][0]) begin
          rmux[p] = shadow_q[p];
        end else begin
          rmux[p]   = evt_ext[eidx[p]][31:0];
          hmux[p]   = evt_ext[eidx[p]][63:32];
          lo_hit[p] = 1'b1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        rdata_q[p]  <= '0;
        shadow_q[p] <= '0;
      end else if (rd[p]) begin
        rdata_q[p] <= rmux[p];
        if (lo_hit[p]) shadow_q[p] <= hmux[p];
      end
    end
  end

endmodule

// File: tb/tb_core_debug_regs.sv
// tb_core_debug_regs: directed vectors and hand sequences for core_debug_regs.
// Event-counter expectations follow CORE_DBG_EVENT_CNT_EN.
module tb_core_debug_regs;

  localparam logic [5:0] A_CTRL  = 6'd0;
  localparam logic [5:0] A_STAT  = 6'd1;
  localparam logic [5:0] A_STEPS = 6'd2;
  localparam logic [5:0] A_CYC_L = 6'd3;
  localparam logic [5:0] A_CYC_H = 6'd4;
  localparam logic [5:0] A_INS_L = 6'd5;
  localparam logic [5:0] A_NONE  = 6'd7;

`ifdef CORE_DBG_EVENT_CNT_EN
  localparam logic [31:0] EV7 = 32'd7;
`else
  localparam logic [31:0] EV7 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        retire;
  logic [3:0]  event_in;
  logic        core_run;
  logic        halted;
  logic [5:0]  s1_address;
  logic        s1_read;
  logic [31:0] s1_readdata;
  logic        s1_write;
  logic [31:0] s1_writedata;
  logic [5:0]  s2_address;
  logic        s2_read;
  logic [31:0] s2_readdata;
  logic        s2_write;
  logic [31:0] s2_writedata;

  core_debug_regs #(
    .NUM_EVENTS(4),
    .CNT_WIDTH (48)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .retire      (retire),
    .event_in    (event_in),
    .core_run    (core_run),
    .halted      (halted),
    .s1_address  (s1_address),
    .s1_read     (s1_read),
    .s1_readdata (s1_readdata),
    .s1_write    (s1_write),
    .s1_writedata(s1_writedata),
    .s2_address  (s2_address),
    .s2_read     (s2_read),
    .s2_readdata (s2_readdata),
    .s2_write    (s2_write),
    .s2_writedata(s2_writedata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r1;
    logic        w1;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic [31:0] e1;
    logic        r2;
    logic        w2;
    logic [5:0]  a2;
    logic [31:0] d2;
    logic [31:0] e2;
    logic        run;
  } vec_t;

  vec_t tv [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(
    input string n,
    input logic r1, input logic w1, input logic [5:0] a1,
    input logic [31:0] d1, input logic [31:0] e1,
    input logic r2, input logic w2, input logic [5:0] a2,
    input logic [31:0] d2, input logic [31:0] e2,
    input logic run
  );
    vec_t v;
    v.name = n;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.e1 = e1;
    v.r2 = r2; v.w2 = w2; v.a2 = a2; v.d2 = d2; v.e2 = e2;
    v.run = run;
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  task automatic s1_op(input logic r, input logic w,
                       input logic [5:0] a, input logic [31:0] d);
    s1_read = r; s1_write = w; s1_address = a; s1_writedata = d;
  endtask

  task automatic s2_op(input logic r, input logic w,
                       input logic [5:0] a, input logic [31:0] d);
    s2_read = r; s2_write = w; s2_address = a; s2_writedata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    s1_read = 1'b0; s1_write = 1'b0;
    s2_read = 1'b0; s2_write = 1'b0;
  endtask

  logic [9:0] ret_pat = 10'b0101011011;
  int         run_cnt;
  logic [5:0] run_seq;

  initial begin
    // state entering the table: MODE=1, STEPS=0, STEP_DONE=1, stopped
    tv.push_back(mk("halt",      0,1,A_CTRL, 32'h3, 0,   0,0,0,      0,     0, 0));
    tv.push_back(mk("steps_coll",0,1,A_STEPS,32'd5, 0,   0,1,A_STEPS,32'd9, 0, 0));
    tv.push_back(mk("steps_rd",  1,0,A_STEPS,0,32'd9,    1,0,A_STAT, 0,32'h2, 0));
    tv.push_back(mk("clr_run",   0,1,A_CTRL, 32'h5, 0,   0,0,0,      0,     0, 1));
    tv.push_back(mk("halt2",     0,0,0,      0,     0,   0,1,A_CTRL, 32'h3, 0, 0));
    tv.push_back(mk("steps_dec", 1,0,A_STEPS,0,32'd8,    1,0,A_CYC_L,0,32'd1, 0));
    tv.push_back(mk("cyc_stop",  1,0,A_CYC_L,0,32'd1,    1,0,A_INS_L,0,32'd0, 0));
    tv.push_back(mk("ctrl_rd",   0,1,A_STAT, 32'hff,0,   1,0,A_CTRL, 0,32'h3, 0));
    tv.push_back(mk("ro_wr",     0,1,A_CYC_L,32'h55,0,   1,0,A_STAT, 0,32'h2, 0));
    tv.push_back(mk("ro_chk",    1,0,A_CYC_L,0,32'd1,    1,0,A_NONE, 0,32'd0, 0));
    tv.push_back(mk("unmap",     1,0,6'd40,  0,32'd0,    0,1,A_NONE, 32'hffff,0,0));
    tv.push_back(mk("ctrl_coll", 0,1,A_CTRL, 32'h0, 0,   0,1,A_CTRL, 32'h2, 0, 0));
    tv.push_back(mk("ctrl_rd2",  1,0,A_CTRL, 0,32'h2,    1,0,A_STEPS,0,32'd8, 0));

    reset = 1'b1; retire = 1'b0; event_in = '0;
    s1_op(0, 0, 0, 0);
    s2_op(0, 0, 0, 0);
    tick();
    tick();
    check("rst_run",    32'(core_run), 32'd1);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rd1",    s1_readdata, 32'd0);
    check("rst_rd2",    s2_readdata, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      retire = ret_pat[i];
      tick();
    end
    retire = 1'b0;
    s1_op(1, 0, A_CYC_L, 0);
    s2_op(1, 0, A_INS_L, 0);
    tick();
    check("cycle_10",  s1_readdata, 32'd10);
    check("instret_6", s2_readdata, 32'd6);
    s1_op(1, 0, A_STAT, 0);
    tick();
    check("status_run", s1_readdata, 32'h1);

    // step mode: exactly three enabled cycles
    s2_op(0, 1, A_CTRL, 32'h1);
    tick();
    s2_op(0, 1, A_STEPS, 32'd3);
    tick();
    run_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      run_seq[i] = core_run;
      if (core_run) run_cnt++;
      tick();
    end
    check("step_cnt",   32'(run_cnt), 32'd3);
    check("step_first", 32'(run_seq[0]), 32'd1);
    check("step_drop",  32'(run_seq[3]), 32'd0);
    s1_op(1, 0, A_STEPS, 0);
    s2_op(1, 0, A_STAT, 0);
    tick();
    check("steps_zero", s1_readdata, 32'd0);
    check("status_done", s2_readdata, 32'h6);

    foreach (tv[i]) begin
      s1_op(tv[i].r1, tv[i].w1, tv[i].a1, tv[i].d1);
      s2_op(tv[i].r2, tv[i].w2, tv[i].a2, tv[i].d2);
      tick();
      if (tv[i].r1) check({tv[i].name, "_s1"}, s1_readdata, tv[i].e1);
      if (tv[i].r2) check({tv[i].name, "_s2"}, s2_readdata, tv[i].e2);
      check({tv[i].name, "_run"}, 32'(core_run), 32'(tv[i].run));
      check({tv[i].name, "_halted"}, 32'(halted), 32'(!tv[i].run));
    end

    // shadow: L read latches H, H moves before the H read
    dut.cycle_q = 48'h00FF_FFFF_FFFF;
    s1_op(1, 0, A_CYC_L, 0);
    s2_op(0, 1, A_CTRL, 32'h0);
    tick();
    check("shd_lo", s1_readdata, 32'hFFFF_FFFF);
    tick();
    s1_op(1, 0, A_CYC_H, 0);
    s2_op(0, 1, A_CTRL, 32'h2);
    tick();
    check("shd_hi", s1_readdata, 32'h0000_00FF);
    s2_op(1, 0, A_CYC_L, 0);
    tick();
    check("live_lo", s2_readdata, 32'd1);
    s2_op(1, 0, A_CYC_H, 0);
    tick();
    check("live_hi", s2_readdata, 32'h0000_0100);

    // wrap: one step cycle from all-ones
    s1_op(0, 1, A_STEPS, 32'd0);
    tick();
    s2_op(0, 1, A_CTRL, 32'h1);
    tick();
    check("wrap_stop", 32'(core_run), 32'd0);
    dut.cycle_q = 48'hFFFF_FFFF_FFFF;
    s1_op(0, 1, A_STEPS, 32'd1);
    tick();
    check("wrap_go", 32'(core_run), 32'd1);
    tick();
    check("wrap_end", 32'(core_run), 32'd0);
    s2_op(1, 0, A_CYC_L, 0);
    tick();
    check("wrap_lo", s2_readdata, 32'd0);
    s2_op(1, 0, A_CYC_H, 0);
    s1_op(1, 0, A_STAT, 0);
    tick();
    check("wrap_hi", s2_readdata, 32'd0);
    check("wrap_stat", s1_readdata, 32'h6);

    // event counters, then clear while halting
    s2_op(0, 1, A_CTRL, 32'h4);
    tick();
    event_in = 4'b0101;
    repeat (7) tick();
    event_in = 4'b0000;
    s1_op(0, 1, A_CTRL, 32'h2);
    tick();
    s1_op(1, 0, 6'd8, 0);
    s2_op(1, 0, 6'd10, 0);
    tick();
    check("evt0", s1_readdata, EV7);
    check("evt1", s2_readdata, 32'd0);
    s1_op(1, 0, 6'd12, 0);
    s2_op(1, 0, 6'd14, 0);
    tick();
    check("evt2", s1_readdata, EV7);
    check("evt3", s2_readdata, 32'd0);
    s1_op(1, 0, A_CYC_L, 0);
    tick();
    check("evt_cyc", s1_readdata, 32'd8);
    s1_op(0, 1, A_CTRL, 32'h6);
    tick();
    s1_op(1, 0, A_CTRL, 0);
    s2_op(1, 0, 6'd8, 0);
    tick();
    check("clr_ctrl", s1_readdata, 32'h2);
    check("clr_evt0", s2_readdata, 32'd0);
    s1_op(1, 0, A_CYC_L, 0);
    s2_op(1, 0, 6'd12, 0);
    tick();
    check("clr_cyc",  s1_readdata, 32'd0);
    check("clr_evt2", s2_readdata, 32'd0);

    // reset in the middle of a step run
    s1_op(0, 1, A_STEPS, 32'd20);
    tick();
    s2_op(0, 1, A_CTRL, 32'h1);
    tick();
    tick();
    tick();
    s1_op(1, 0, A_STEPS, 0);
    s2_op(1, 0, A_CTRL, 0);
    tick();
    check("mid_steps", s1_readdata, 32'd18);
    check("mid_ctrl",  s2_readdata, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_rd1",    s1_readdata, 32'd0);
    check("mrst_rd2",    s2_readdata, 32'd0);
    check("mrst_run",    32'(core_run), 32'd1);
    check("mrst_halted", 32'(halted), 32'd0);
    s1_op(1, 0, A_STEPS, 0);
    s2_op(1, 0, A_CTRL, 0);
    tick();
    check("mrst_steps", s1_readdata, 32'd0);
    check("mrst_mode",  s2_readdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
